// File: rtl/idu_mt_pkg.sv
// Shared decode types for the multithreaded RV32I(+M) decode stage.
// Holds the decoded bundle layout, ALU op encoding, opcode constants and immediate kinds.
package cpu_types;

  localparam int CPU_XLEN = 32;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  // Encoded identically to funct3 of OP/OP-IMM so decode can pass fn3 straight through.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_logic_op_t;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
  } imm_type_t;

  typedef struct packed {
    logic [4:0]          rs1;
    logic                rs1_en;
    logic [4:0]          rs2;
    logic                rs2_en;
    logic [4:0]          rd;
    logic                rd_en;
    logic                jal_req;
    logic                jalr_req;
    logic                b_req;
    logic                lui_req;
    logic                auipc_req;
    logic                l_req;
    logic                s_req;
    logic                mul_req;
    logic [2:0]          fn3;
    alu_logic_op_t       alu_logic_op;
    logic                logic_op;
    logic                sub;
    logic                sra;
    logic [CPU_XLEN-1:0] imm;
    logic                illegal;
  } decoded_inst_t;

endpackage

// File: rtl/idu_mt_dec.sv
// Combinational RV32I(+optional M) instruction decoder.
// Any encoding outside the supported set yields an all-zero bundle with only illegal set.
module idu_mt_dec
  import cpu_types::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_M_EXT = 1'b0
) (
  input  logic [31:0]   i_inst,
  output decoded_inst_t o_dec
);

  decoded_inst_t   w_dec;
  imm_type_t       w_imm_t;
  logic            w_has_imm, w_ok, w_use_rd, w_use_rs1, w_use_rs2;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm;

  assign w_f3 = i_inst[14:12];
  assign w_f7 = i_inst[31:25];

  always_comb begin
    w_dec              = '0;
    w_dec.rs1          = i_inst[19:15];
    w_dec.rs2          = i_inst[24:20];
    w_dec.rd           = i_inst[11:7];
    w_dec.fn3          = w_f3;
    w_dec.alu_logic_op = ALU_ADD;
    w_imm_t            = IMM_I;
    w_has_imm          = 1'b1;
    w_ok               = 1'b0;
    w_use_rd           = 1'b0;
    w_use_rs1          = 1'b0;
    w_use_rs2          = 1'b0;
    if (i_inst[1:0] == 2'b11) begin
      case (i_inst[6:2])
        OPC_LUI:   begin w_ok = 1'b1; w_use_rd = 1'b1; w_dec.lui_req = 1'b1; w_imm_t = IMM_U; end
        OPC_AUIPC: begin w_ok = 1'b1; w_use_rd = 1'b1; w_dec.auipc_req = 1'b1; w_imm_t = IMM_U; end
        OPC_JAL:   begin w_ok = 1'b1; w_use_rd = 1'b1; w_dec.jal_req = 1'b1; w_imm_t = IMM_J; end
        OPC_JALR: begin
          w_ok = (w_f3 == 3'b000); w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_dec.jalr_req = 1'b1;
        end
        OPC_BRANCH: begin
          w_ok = (w_f3[2:1] != 2'b01); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
          w_dec.b_req = 1'b1; w_dec.sub = 1'b1; w_imm_t = IMM_B;
        end
        OPC_LOAD: begin
          w_ok = !(w_f3 == 3'b011 || w_f3[2:1] == 2'b11);
          w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_dec.l_req = 1'b1;
        end
        OPC_STORE: begin
          w_ok = !w_f3[2] && (w_f3[1:0] != 2'b11);
          w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_dec.s_req = 1'b1; w_imm_t = IMM_S;
        end
        OPC_OP_IMM: begin
          w_use_rd = 1'b1; w_use_rs1 = 1'b1;
          w_dec.alu_logic_op = alu_logic_op_t'(w_f3);
          w_dec.logic_op     = w_f3[2] && (w_f3[1] || !w_f3[0]);
          w_dec.sub          = (w_f3[2:1] == 2'b01);
          // SLLI/SRLI/SRAI reuse the funct7 slot, so it must be validated here.
          if (w_f3[1:0] == 2'b01) begin
            w_imm_t   = IMM_SH;
            w_ok      = (w_f7 == 7'b0000000) || (w_f3[2] && w_f7 == 7'b0100000);
            w_dec.sra = w_f3[2] && w_f7[5];
          end else begin
            w_ok = 1'b1;
          end
        end
        OPC_OP: begin
          w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_has_imm = 1'b0;
          if (w_f7 == 7'b0000000) begin
            w_ok               = 1'b1;
            w_dec.alu_logic_op = alu_logic_op_t'(w_f3);
            w_dec.logic_op     = w_f3[2] && (w_f3[1] || !w_f3[0]);
            w_dec.sub          = (w_f3[2:1] == 2'b01);
          end else if (w_f7 == 7'b0100000) begin
            w_ok               = (w_f3 == 3'b000) || (w_f3 == 3'b101);
            w_dec.alu_logic_op = alu_logic_op_t'(w_f3);
            w_dec.sub          = (w_f3 == 3'b000);
            w_dec.sra          = (w_f3 == 3'b101);
          end else if (w_f7 == 7'b0000001) begin
            w_ok          = EN_M_EXT;
            w_dec.mul_req = 1'b1;
          end else begin
            w_ok = 1'b0;
          end
        end
        default: w_ok = 1'b0;
      endcase
    end

    case (w_imm_t)
      IMM_I:   w_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
      IMM_S:   w_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_B:   w_imm = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                        i_inst[11:8], 1'b0};
      IMM_U:   w_imm = {{(XLEN-31){i_inst[31]}}, i_inst[30:12], 12'b0};
      IMM_J:   w_imm = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                        i_inst[30:21], 1'b0};
      IMM_SH:  w_imm = {{(XLEN-5){1'b0}}, i_inst[24:20]};
      default: w_imm = '0;
    endcase

    w_dec.imm    = w_has_imm ? w_imm : '0;
    w_dec.rs1_en = w_use_rs1;
    w_dec.rs2_en = w_use_rs2;
    w_dec.rd_en  = w_use_rd && (i_inst[11:7] != 5'd0);

    if (!w_ok) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/idu_mt.sv
// Multithreaded decode stage: registered output with a one-entry skid for full throughput,
// per-thread flush, and per-thread trap hold that drops a thread's input after an illegal op.
module idu_mt
  import cpu_types::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_LEN    = 32,
  parameter int NUM_THREADS = 4,
  parameter bit EN_M_EXT    = 1'b0,
  localparam int TID_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int PC_W       = ADDR_LEN - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_inst_i,
  input  logic [PC_W-1:0]        in_pc_i,
  input  logic [TID_W-1:0]       in_tid_i,
  input  logic                   flush_i,
  input  logic [TID_W-1:0]       flush_tid_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output decoded_inst_t          out_dec_o,
  output logic [PC_W-1:0]        out_pc_o,
  output logic [TID_W-1:0]       out_tid_o,
  output logic [NUM_THREADS-1:0] trap_hold_o
);

  decoded_inst_t          r_main_dec, r_skid_dec, w_in_dec, w_load_dec;
  logic                   r_main_vld, r_skid_vld;
  logic [PC_W-1:0]        r_main_pc, r_skid_pc, w_load_pc;
  logic [TID_W-1:0]       r_main_tid, r_skid_tid, w_load_tid;
  logic [NUM_THREADS-1:0] r_hold, w_hold_nxt;
  logic                   w_flush_main, w_flush_skid, w_skid_live, w_in_keep;
  logic                   w_main_load, w_load_vld;

  idu_mt_dec #(.XLEN(XLEN), .EN_M_EXT(EN_M_EXT)) u_dec (
    .i_inst (in_inst_i),
    .o_dec  (w_in_dec)
  );

  // Ready depends only on the skid flag, so out_ready_i never reaches in_ready_o.
  assign in_ready_o = !r_skid_vld;

  always_comb begin
    w_flush_main = flush_i && r_main_vld && (r_main_tid == flush_tid_i);
    w_flush_skid = flush_i && r_skid_vld && (r_skid_tid == flush_tid_i);
    w_skid_live  = r_skid_vld && !w_flush_skid;
    w_in_keep    = in_valid_i && in_ready_o && !r_hold[in_tid_i]
                   && !(flush_i && (in_tid_i == flush_tid_i));
    w_main_load  = !r_main_vld || out_ready_i || w_flush_main;
    // The skid entry is always older than the input, so it wins the main slot.
    w_load_vld   = w_skid_live || w_in_keep;
    w_load_dec   = w_skid_live ? r_skid_dec : w_in_dec;
    w_load_pc    = w_skid_live ? r_skid_pc  : in_pc_i;
    w_load_tid   = w_skid_live ? r_skid_tid : in_tid_i;

    w_hold_nxt = r_hold;
    if (w_main_load && w_load_vld && w_load_dec.illegal)
      w_hold_nxt[w_load_tid] = 1'b1;
    if (flush_i)
      w_hold_nxt[flush_tid_i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_main_dec <= '0;
      r_main_pc  <= '0;
      r_main_tid <= '0;
      r_skid_vld <= 1'b0;
      r_skid_dec <= '0;
      r_skid_pc  <= '0;
      r_skid_tid <= '0;
      r_hold     <= '0;
    end else begin
      r_hold <= w_hold_nxt;
      if (w_main_load) begin
        r_main_vld <= w_load_vld;
        if (w_load_vld) begin
          r_main_dec <= w_load_dec;
          r_main_pc  <= w_load_pc;
          r_main_tid <= w_load_tid;
        end
      end
      r_skid_vld <= !w_main_load && (w_skid_live || w_in_keep);
      if (!w_main_load && w_in_keep) begin
        r_skid_dec <= w_in_dec;
        r_skid_pc  <= in_pc_i;
        r_skid_tid <= in_tid_i;
      end
    end
  end

  assign out_valid_o = r_main_vld;
  assign out_dec_o   = r_main_dec;
  assign out_pc_o    = r_main_pc;
  assign out_tid_o   = r_main_tid;
  assign trap_hold_o = r_hold;

endmodule
